// File: rtl/bus_pkg.sv
// Shared bus types and default widths for the bus master, slaves and bench.
// Exports: state_t, op_t, DEF_BUS_WIDTH, DEF_ADDR_WIDTH, TIMER_WIDTH.
package bus_pkg;

    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int TIMER_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RELEASE
    } state_t;

    typedef enum logic {
        OP_WRITE,
        OP_READ
    } op_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Loadable 4-bit down-counter with a zero flag; holds at zero.
// Ports: clock, reset_n, load, load_value, dec in; zero out.
module bus_wait_timer
    import bus_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    input  logic                   dec,
    output logic                   zero
);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_slave_mem.sv
// Bus slave: address-window decode, wait states, small register array.
// Ports: clock, reset_n, WB, RB, master_address, master_data in;
//        slave_data, Ack, err, busy out (all registered).
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int                    BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(8'h02),
    parameter int                    DEPTH       = 4,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  WB,
    input  logic                  RB,
    input  logic [ADDR_WIDTH-1:0] master_address,
    input  logic [BUS_WIDTH-1:0]  master_data,
    output logic [BUS_WIDTH-1:0]  slave_data,
    output logic                  Ack,
    output logic                  err,
    output logic                  busy
);

    localparam int OFF_W = $clog2(DEPTH);
    // One extra bit so a window ending at the top of the map cannot wrap.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t               state;
    op_t                  op;
    logic [OFF_W-1:0]     offset;
    logic [BUS_WIDTH-1:0] wdata;
    logic [BUS_WIDTH-1:0] mem [DEPTH];

    logic             hit;
    logic [OFF_W-1:0] req_off;
    logic             accept;
    logic             tmr_zero;

    assign hit = (master_address >= BASE_ADDR) &&
                 ({1'b0, master_address} <= LAST_ADDR);
    assign req_off = OFF_W'(master_address - BASE_ADDR);
    assign accept = (state == IDLE) && hit && (WB ^ RB);

    bus_wait_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .load_value (TIMER_WIDTH'(WAIT_CYCLES)),
        .dec        (state == WAIT),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= OP_WRITE;
            offset     <= '0;
            wdata      <= '0;
            slave_data <= '0;
            Ack        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            Ack <= 1'b0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        hit && WB && RB: begin
                            err   <= 1'b1;
                            busy  <= 1'b1;
                            state <= RELEASE;
                        end
                        accept: begin
                            op     <= WB ? OP_WRITE : OP_READ;
                            offset <= req_off;
                            wdata  <= master_data;
                            busy   <= 1'b1;
                            state  <= WAIT;
                        end
                        default: ;
                    endcase
                end
                WAIT: begin
                    if (tmr_zero) begin
                        Ack   <= 1'b1;
                        state <= ACK;
                        if (op == OP_WRITE) begin
                            mem[offset] <= wdata;
                        end else begin
                            slave_data <= mem[offset];
                        end
                    end
                end
                ACK: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Wait for the master to drop a held request.
                    if (!WB && !RB) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem (WAIT_CYCLES=2 and 0 instances).
// Read data is checked against a queue filled from a bench memory model.
module tb_bus_slave_mem;
    import bus_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       WB, RB, WB0, RB0;
    logic [7:0] addr, wdata, addr0, wdata0;
    logic [7:0] rdata, rdata0;
    logic       ack, err, busy, ack0, err0, busy0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model  [4];
    logic [7:0] model0 [4];
    logic [7:0] exp_q  [$];

    always #5 clock = ~clock;

    bus_slave_mem #(
        .BUS_WIDTH(8), .ADDR_WIDTH(8), .BASE_ADDR(8'h02),
        .DEPTH(4), .WAIT_CYCLES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .WB(WB), .RB(RB),
        .master_address(addr), .master_data(wdata),
        .slave_data(rdata), .Ack(ack), .err(err), .busy(busy)
    );

    bus_slave_mem #(
        .BUS_WIDTH(8), .ADDR_WIDTH(8), .BASE_ADDR(8'h02),
        .DEPTH(4), .WAIT_CYCLES(0)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .WB(WB0), .RB(RB0),
        .master_address(addr0), .master_data(wdata0),
        .slave_data(rdata0), .Ack(ack0), .err(err0), .busy(busy0)
    );

    function automatic logic sel_ack(input logic sel);
        return sel ? ack0 : ack;
    endfunction

    // One full transfer on either instance (sel=1 -> WAIT_CYCLES=0 copy).
    task automatic transfer(input logic sel, input logic wr,
                            input logic [7:0] a, input logic [7:0] d);
        int         lat;
        int         want_lat;
        logic [1:0] off;
        logic [7:0] exp;
        logic [7:0] got;
        logic       b;
        want_lat = sel ? 1 : 3;
        off = 2'(a - 8'h02);
        @(negedge clock);
        if (sel) begin
            WB0 = wr; RB0 = !wr; addr0 = a; wdata0 = d;
        end else begin
            WB = wr; RB = !wr; addr = a; wdata = d;
        end
        if (wr) begin
            if (sel) model0[off] = d;
            else model[off] = d;
        end else begin
            exp_q.push_back(sel ? model0[off] : model[off]);
        end
        @(posedge clock);
        lat = 0;
        while (!sel_ack(sel) && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        n_cmp++;
        if (lat != want_lat) begin
            n_bad++;
            $display("FAIL ack_latency addr=%h got=%0d want=%0d",
                     a, lat, want_lat);
        end
        if (!wr) begin
            exp = exp_q.pop_front();
            got = sel ? rdata0 : rdata;
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL read_data addr=%h got=%h want=%h",
                         a, got, exp);
            end
        end
        @(posedge clock); #1;
        n_cmp++;
        if (sel_ack(sel) !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_width addr=%h got=%b want=0", a, sel_ack(sel));
        end
        WB = 0; RB = 0; WB0 = 0; RB0 = 0;
        @(posedge clock); #1;
        b = sel ? busy0 : busy;
        n_cmp++;
        if (b !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_release got=%b want=0", b);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        WB = 0; RB = 0; addr = 0; wdata = 0;
        WB0 = 0; RB0 = 0; addr0 = 0; wdata0 = 0;
        for (int i = 0; i < 4; i++) begin
            model[i] = 8'h00;
            model0[i] = 8'h00;
        end
        #3;
        n_cmp++;
        if ({ack, err, busy, rdata, ack0, err0, busy0, rdata0} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b%b%b %h %b%b%b %h want=0",
                     ack, err, busy, rdata, ack0, err0, busy0, rdata0);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_miss();
        @(negedge clock);
        WB = 1; addr = 8'h01; wdata = 8'hEE;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({ack, err, busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL miss_ignored cyc=%0d got=%b%b%b want=000",
                         i, ack, err, busy);
            end
        end
        WB = 0;
        for (int a = 2; a <= 5; a++) transfer(0, 0, 8'(a), 8'h00);
    endtask

    task automatic test_write_read();
        transfer(0, 1, 8'h02, 8'hAA);
        transfer(0, 0, 8'h02, 8'h00);
        transfer(0, 1, 8'h03, 8'h3C);
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (rdata !== 8'hAA) begin
            n_bad++;
            $display("FAIL slave_data_hold got=%h want=aa", rdata);
        end
    endtask

    task automatic test_window_edges();
        transfer(0, 1, 8'h02, 8'h11);
        transfer(0, 1, 8'h05, 8'h55);
        @(negedge clock);
        WB = 1; addr = 8'h06; wdata = 8'hDD;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({ack, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL above_window cyc=%0d got=%b%b want=00",
                         i, ack, busy);
            end
        end
        WB = 0;
        transfer(0, 0, 8'h02, 8'h00);
        transfer(0, 0, 8'h05, 8'h00);
    endtask

    task automatic test_protocol_error();
        @(negedge clock);
        WB = 1; RB = 1; addr = 8'h03; wdata = 8'hFF;
        @(posedge clock); #1;
        n_cmp++;
        if ({err, ack, busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL err_pulse got=%b%b%b want=101", err, ack, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({err, ack, busy} !== 3'b001) begin
                n_bad++;
                $display("FAIL err_hold cyc=%0d got=%b%b%b want=001",
                         i, err, ack, busy);
            end
        end
        WB = 0;
        @(posedge clock); #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL err_one_dropped busy=%b want=1", busy);
        end
        RB = 0;
        @(posedge clock); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_release busy=%b want=0", busy);
        end
        transfer(0, 0, 8'h03, 8'h00);
    endtask

    task automatic test_held_request();
        int acks;
        acks = 0;
        @(negedge clock);
        WB = 1; addr = 8'h04; wdata = 8'h99;
        model[2] = 8'h99;
        for (int i = 0; i < 14; i++) begin
            @(posedge clock); #1;
            if (ack) acks++;
        end
        n_cmp++;
        if (acks != 1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL held_single_ack acks=%0d busy=%b want=1 1",
                     acks, busy);
        end
        WB = 0;
        @(posedge clock); #1;
        transfer(0, 1, 8'h04, 8'h9A);
        transfer(0, 0, 8'h04, 8'h00);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clock);
        WB = 1; addr = 8'h04; wdata = 8'h77;
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_cmp++;
        if (busy !== 1'b1 || rdata !== 8'h9A) begin
            n_bad++;
            $display("FAIL pre_reset busy=%b data=%h want=1 9a", busy, rdata);
        end
        reset_n = 0;
        #1;
        n_cmp++;
        if ({ack, busy, rdata} !== 10'b0) begin
            n_bad++;
            $display("FAIL async_reset got=%b%b %h want=0", ack, busy, rdata);
        end
        for (int i = 0; i < 4; i++) begin
            model[i] = 8'h00;
            model0[i] = 8'h00;
        end
        @(negedge clock);
        WB = 0;
        reset_n = 1;
        transfer(0, 0, 8'h04, 8'h00);
    endtask

    task automatic test_wait0();
        transfer(1, 1, 8'h04, 8'h5A);
        transfer(1, 0, 8'h04, 8'h00);
        transfer(1, 0, 8'h02, 8'h00);
    endtask

    initial begin
        test_reset();
        test_miss();
        test_write_read();
        test_window_edges();
        test_protocol_error();
        test_held_request();
        test_reset_mid_op();
        test_wait0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
